// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and frame constants for the program loader
package program_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTE_W         = 8;
  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  // log2 of the bytes per word: word index to byte address, and byte counter width
  localparam int ADDR_SHIFT     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream and program memory write port bundle
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  ByteValid;
  logic [7:0]            ByteData;
  logic                  ByteReady;
  logic                  WriteEnable;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;

  modport master (
    input  ByteValid, ByteData,
    output ByteReady, WriteEnable, WriteAddress, WriteData
  );

  modport slave (
    output ByteValid, ByteData,
    input  ByteReady, WriteEnable, WriteAddress, WriteData
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - MSB-first byte-to-word shift register with completion strobe
module program_loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  word_capture,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam logic [ADDR_SHIFT-1:0] LAST_BYTE = ADDR_SHIFT'(BYTES_PER_WORD - 1);

  // Only the first three bytes need holding; the fourth is taken straight off the bus.
  logic [DATA_WIDTH-BYTE_W-1:0] shift_q;
  logic [ADDR_SHIFT-1:0]        cnt_q;

  assign word_capture = byte_en && (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_capture;
      if (byte_en) begin
        shift_q <= {shift_q[DATA_WIDTH-2*BYTE_W-1:0], byte_data};
        cnt_q   <= word_capture ? '0 : cnt_q + 1'b1;
        if (word_capture) begin
          word <= {shift_q, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader filling program memory from a framed, checksummed byte stream
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  program_loader_if.master bus,
  output logic             CpuHold,
  output logic             LoadDone,
  output logic             LoadError
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEMORY_DEPTH);

  loader_state_t         state_q, state_d;
  logic [BYTE_W-1:0]     len_hi_q;
  logic [BYTE_W-1:0]     xor_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      index_q;
  logic [LEN_W-1:0]      frame_len;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] word;
  logic                  byte_ready;
  logic                  accept;
  logic                  restart;
  logic                  word_capture;
  logic                  word_valid;

  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA)   || (state_q == CHECK);
  assign accept     = bus.ByteValid && byte_ready;
  assign restart    = Start && ((state_q == DONE) || (state_q == ERROR));
  assign frame_len  = {len_hi_q, bus.ByteData};

  assign bus.ByteReady    = byte_ready;
  assign bus.WriteEnable  = word_valid;
  assign bus.WriteAddress = addr_q;
  assign bus.WriteData    = word;

  program_loader_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear        (restart),
    .byte_en      (accept && (state_q == DATA)),
    .byte_data    (bus.ByteData),
    .word_capture (word_capture),
    .word         (word),
    .word_valid   (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    CpuHold   = 1'b1;
    LoadDone  = 1'b0;
    LoadError = 1'b0;
    case (state_q)
      LEN_HI: if (accept) state_d = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (frame_len > MAX_LEN) begin
            state_d = ERROR;
          end else if (frame_len == '0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      // The last word's write strobe lands in the first CHECK cycle.
      DATA:   if (word_capture && ((index_q + 16'd1) == len_q)) state_d = CHECK;
      CHECK:  if (accept) state_d = (bus.ByteData == xor_q) ? DONE : ERROR;
      DONE: begin
        CpuHold  = 1'b0;
        LoadDone = 1'b1;
        if (Start) state_d = LEN_HI;
      end
      ERROR: begin
        LoadError = 1'b1;
        if (Start) state_d = LEN_HI;
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi_q <= '0;
      len_q    <= '0;
      index_q  <= '0;
      xor_q    <= '0;
      addr_q   <= '0;
    end else if (restart) begin
      len_hi_q <= '0;
      len_q    <= '0;
      index_q  <= '0;
      xor_q    <= '0;
    end else begin
      if (accept && (state_q != CHECK)) xor_q <= xor_q ^ bus.ByteData;
      if (accept && (state_q == LEN_HI)) len_hi_q <= bus.ByteData;
      if (accept && (state_q == LEN_LO)) len_q <= frame_len;
      if (word_capture) begin
        addr_q  <= DATA_WIDTH'(index_q) << ADDR_SHIFT;
        index_q <= index_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  logic Start;
  logic CpuHold;
  logic LoadDone;
  logic LoadError;

  program_loader_if #(.DATA_WIDTH(32)) bus ();

  program_loader #(
    .MEMORY_DEPTH (32),
    .DATA_WIDTH   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .bus       (bus),
    .CpuHold   (CpuHold),
    .LoadDone  (LoadDone),
    .LoadError (LoadError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cycle;
  } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wr_count = 0;
  wr_t         exp_q[$];
  logic [31:0] img[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every strobe must match the next expected write, one cycle after its 4th byte.
  always @(negedge clk) begin
    wr_t e;
    if (bus.WriteEnable === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.WriteAddress, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.WriteAddress, e.addr);
        check("wr_data", bus.WriteData, e.data);
        check("wr_latency", cyc, e.cycle);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [31:0] addr,
                           input logic [31:0] data);
    int  waited = 0;
    wr_t e;
    bus.ByteValid = 1'b1;
    bus.ByteData  = b;
    while (bus.ByteReady !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (bus.ByteReady !== 1'b1) begin
      check("byte_ready_timeout", bus.ByteReady, 1);
      return;
    end
    if (push) begin
      e.addr  = addr;
      e.data  = data;
      e.cycle = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.ByteValid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] flip, input bit gaps);
    logic [15:0] len;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    len = 16'(n);
    x   = 8'h00;
    maybe_gap(gaps);
    send_byte(len[15:8], 1'b0, 0, 0);
    x ^= len[15:8];
    maybe_gap(gaps);
    send_byte(len[7:0], 1'b0, 0, 0);
    x ^= len[7:0];
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
        b = w[31-8*j -: 8];
        maybe_gap(gaps);
        send_byte(b, j == 3, 32'(i * 4), w);
        x ^= b;
      end
    end
    maybe_gap(gaps);
    send_byte(x ^ flip, 1'b0, 0, 0);
    bus.ByteValid = 1'b0;
    repeat (2) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
  endtask

  task automatic expect_status(input logic done, input logic err, input logic hold,
                               input logic ready);
    check("load_done", LoadDone, done);
    check("load_error", LoadError, err);
    check("cpu_hold", CpuHold, hold);
    check("byte_ready", bus.ByteReady, ready);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    expect_status(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic expect_reset_outputs();
    expect_status(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_we", bus.WriteEnable, 0);
    check("rst_waddr", bus.WriteAddress, 0);
    check("rst_wdata", bus.WriteData, 0);
  endtask

  initial begin
    int base;
    reset         = 1'b1;
    Start         = 1'b0;
    bus.ByteValid = 1'b0;
    bus.ByteData  = 8'h00;
    repeat (3) @(negedge clk);
    expect_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    // Two words back to back, checksum 0x0C
    img[0] = 32'h2008_0005;
    img[1] = 32'h2009_000A;
    base = wr_count;
    send_frame(2, 8'h00, 1'b0);
    check("n2_writes", wr_count - base, 2);
    expect_status(1'b1, 1'b0, 1'b0, 1'b0);

    // Empty image, good then bad checksum
    pulse_start();
    base = wr_count;
    send_frame(0, 8'h00, 1'b0);
    check("n0_writes", wr_count - base, 0);
    expect_status(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    send_frame(0, 8'h01, 1'b0);
    expect_status(1'b0, 1'b1, 1'b1, 1'b0);

    // Length overflow: ERROR right after the low length byte, stream then stalls
    pulse_start();
    base = wr_count;
    send_byte(8'h00, 1'b0, 0, 0);
    send_byte(8'h21, 1'b0, 0, 0);
    expect_status(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    bus.ByteValid = 1'b0;
    check("n33_writes", wr_count - base, 0);
    expect_status(1'b0, 1'b1, 1'b1, 1'b0);

    // Single word with bad checksum still writes, then a good reload
    pulse_start();
    img[0] = 32'h1234_5678;
    base = wr_count;
    send_frame(1, 8'h01, 1'b0);
    check("bad_ck_writes", wr_count - base, 1);
    expect_status(1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    img[0] = 32'hDEAD_BEEF;
    send_frame(1, 8'h00, 1'b0);
    expect_status(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-word, then a fresh frame must not see stale bytes
    pulse_start();
    send_byte(8'h00, 1'b0, 0, 0);
    send_byte(8'h01, 1'b0, 0, 0);
    send_byte(8'hAA, 1'b0, 0, 0);
    send_byte(8'hBB, 1'b0, 0, 0);
    bus.ByteValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    expect_reset_outputs();
    reset = 1'b0;
    img[0] = 32'hCAFE_F00D;
    base = wr_count;
    send_frame(1, 8'h00, 1'b0);
    check("post_reset_writes", wr_count - base, 1);
    expect_status(1'b1, 1'b0, 1'b0, 1'b0);

    // Full depth with random source gaps
    pulse_start();
    for (int i = 0; i < 32; i++) img[i] = 32'h1000_0000 + 32'(i) * 32'h0004_0101;
    base = wr_count;
    send_frame(32, 8'h00, 1'b1);
    check("n32_writes", wr_count - base, 32);
    expect_status(1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time controller that fills the instruction store of the MIPS core from a byte stream (UART receiver or test host) before execution starts.
- Parses a framed image: length header, instruction words, XOR checksum. Writes each assembled word to the program memory write port.
- Holds the CPU in stall until the image is loaded and verified.
- Sits between the byte source and the RAM-backed program memory; the fetch path is untouched.

Parameters:
- MEMORY_DEPTH, 32, number of instruction words in program memory.
- DATA_WIDTH, 32, instruction/address width; byte addressing, word-aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  re-arm pulse; honoured only in DONE or ERROR.
- ByteValid  input  1  source has a byte on ByteData.
- ByteData  input  8  stream byte.
- ByteReady  output  1  loader accepts a byte this cycle.
- WriteEnable  output  1  one-cycle program memory write strobe.
- WriteAddress  output  DATA_WIDTH  byte address of the word (word index * 4).
- WriteData  output  DATA_WIDTH  assembled instruction.
- CpuHold  output  1  stall the core/PC while high.
- LoadDone  output  1  image loaded and checksum matched (level).
- LoadError  output  1  length overflow or checksum mismatch (level).

Behaviour:
- Handshake: a byte is consumed only on a cycle where ByteValid && ByteReady. ByteReady=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 elsewhere.
- Frame format:
  - Length N, 16 bits, MSB byte first.
  - N words, 4 bytes each, MSB first (same byte order as the hex image).
  - 1 checksum byte = XOR of all preceding frame bytes, length bytes included.
- States: LEN_HI -> LEN_LO -> DATA -> CHECK -> DONE | ERROR.
- Reset (at any time, including mid-frame):
  - State = LEN_HI; word index, byte counter and running XOR = 0.
  - CpuHold=1, WriteEnable=0, WriteAddress=0, WriteData=0, LoadDone=0, LoadError=0.
- LEN_LO accept:
  - N > MEMORY_DEPTH -> ERROR.
  - N == 0 -> CHECK.
  - Otherwise -> DATA.
- DATA:
  - Bytes shift into a 32-bit assembler.
  - On the 4th byte's accept cycle, the word is registered. The following cycle has WriteEnable=1, WriteData=word, WriteAddress=index*4. Index then increments.
  - Latency from 4th byte handshake to WriteEnable is exactly 1 cycle.
  - Back-to-back bytes are accepted without stalls; at most one write can be pending.
  - After word N is captured -> CHECK.
- CHECK accept:
  - Received byte == running XOR -> DONE; otherwise -> ERROR.
  - The final word's write strobe occurs before or in the same cycle as the CHECK transition; it is never dropped.
- DONE: LoadDone=1, CpuHold=0.
- ERROR: LoadError=1, CpuHold stays 1. Words already written are not rolled back.
- Start in DONE or ERROR:
  - Clears LoadDone and LoadError, sets CpuHold=1, zeroes the counters -> LEN_HI.
  - Start is ignored in all other states.
- Index wraps never: the length check guarantees index < MEMORY_DEPTH; WriteAddress maximum is (MEMORY_DEPTH-1)*4.
- Bytes presented while ByteReady=0 are not consumed (source must hold them).

Decomposition:
- Shared package: state encoding constants (LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR), frame byte widths, the byte-to-word shift constant (4).
- One natural sub-module: word_assembler (byte shift register + 2-bit byte counter + word-complete flag). FSM, counters and checksum stay in the top.

Test Plan:
- N=2, words 0x20080005, 0x2009000A, correct XOR, ByteValid held high:
  - 2 WriteEnable pulses, at addresses 0x0 and 0x4 with matching data, each 1 cycle after the 4th byte.
  - LoadDone=1, CpuHold=0.
- N=0, checksum 0x00 -> no writes, LoadDone=1. Repeat with checksum 0x01 -> LoadError=1, CpuHold=1.
- N=33 with MEMORY_DEPTH=32 -> ERROR right after the 2nd byte, no WriteEnable, ByteReady=0 afterwards.
- N=1, last checksum bit flipped -> word written at 0x0, then LoadError=1; Start pulse, then a valid N=1 frame -> LoadDone=1.
- Reset asserted after 2 of 4 data bytes -> all outputs at reset values next cycle. A fresh N=1 frame then writes address 0x0 correctly (no stale bytes).
- Random ByteValid gaps, N=32 full depth -> 32 writes at addresses 0x0..0x7C, no dropped or duplicated bytes, LoadDone=1.
